mac8_seq_ctrl: RTL
==================

// Module: mac8_seq_ctrl
// PURPOSE
//  Sequences one shared 16-bit adder, instantiated by the parent, to perform 8x8 unsigned multiply-accumulate.
//  Multiply is shift-and-add over WIDTH cycles; the product is then added into a 16-bit accumulator.
//  Sits between the TT user-IO input registers and the adder; owns all adder operand muxing.
//  Accepts one operation per valid/ready handshake and returns the accumulator with valid/ready backpressure.
// PARAMETERS
//  WIDTH   8   operand width; multiply phase lasts WIDTH cycles
//  ACC_W   16  accumulator/adder width; must equal 2*WIDTH
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept (high only in IDLE)
//  op_a       in   WIDTH  multiplicand, unsigned
//  op_b       in   WIDTH  multiplier, unsigned
//  acc_clr    in   1      sampled on accept: start accumulation from 0
//  add_a      out  ACC_W  adder operand A
//  add_b      out  ACC_W  adder operand B
//  add_cin    out  1      adder carry-in, always 0
//  add_sum    in   ACC_W  adder result, combinational from add_a/add_b/add_cin
//  out_valid  out  1      acc_out/acc_ovf valid
//  out_ready  in   1      consumer takes result
//  acc_out    out  ACC_W  accumulator value
//  acc_ovf    out  1      sticky unsigned accumulate overflow
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n low at clk edge):
//   - state=IDLE, acc=0, prod=0, bit counter=0, acc_ovf=0, out_valid=0.
//   - add_a and add_b drive 0.
//   - Reset wins over every other event, including reset in mid-MUL/ACC/DONE; no partial result is emitted.
//  IDLE:
//   - in_ready=1.
//   - On in_valid & in_ready: latch op_a/op_b, prod<=0, cnt<=0, go to MUL.
//   - If acc_clr is high at accept, the accumulation starts from 0 and acc_ovf clears at that edge.
//  MUL (WIDTH cycles, cnt=0..WIDTH-1):
//   - add_a=prod; add_b = b[cnt] ? (zero-extended a << cnt) : 0.
//   - prod<=add_sum each cycle.
//   - After cnt==WIDTH-1, go to ACC.
//   - No carry out of ACC_W is possible in this phase.
//  ACC (1 cycle):
//   - add_a = (clr_latched ? 0 : acc); add_b=prod; acc<=add_sum, wrapping mod 2^ACC_W.
//   - Overflow when add_sum < add_a (unsigned); it sets acc_ovf, which is sticky.
//   - Go to DONE.
//  DONE:
//   - out_valid=1; acc_out=acc; held stable until out_valid & out_ready, then go to IDLE.
//   - in_ready=0; a new request cannot be accepted in the same cycle the result is taken.
//  Outside ACC, acc_out always shows acc; out_valid is 0 outside DONE.
//  Latency: accept edge at cycle 0 -> out_valid high at cycle WIDTH+2. Minimum throughput: one op per WIDTH+3 cycles.
//  add_cin is a constant 0 in every state.
//  Zero operands still run the full WIDTH cycles (fixed latency, no early exit).
// STRUCTURE
//  Shared package mac8_pkg holds:
//   - state typedef {IDLE, MUL, ACC, DONE}, 2-bit;
//   - localparams WIDTH=8, ACC_W=16, CNT_W=$clog2(WIDTH).
//  No sub-module: single FSM plus operand mux.
//  The adder (reversible_16bit_adder) is instantiated by the parent and wired to add_*.
// TESTING
//  1. acc_clr=1, a=3, b=5, out_ready=1 -> out_valid at cycle 10, acc_out=15, acc_ovf=0.
//  2. acc_clr=1, a=255, b=255 -> acc_out=65025 (0xFE01), acc_ovf=0.
//  3. a=200, b=200 with clr, then a=200, b=200 without clr -> 40000, then 14464 (0x3880) with acc_ovf=1; next op with acc_clr clears acc_ovf.
//  4. Hold out_ready=0 for 5 cycles in DONE -> out_valid and acc_out stable, in_ready=0; release -> IDLE next cycle.
//  5. rst_n low during MUL cnt=4 -> next cycle state IDLE, acc=0, in_ready=1, out_valid never asserted.
//  6. Operations a=0/b=9, then a=7/b=0 -> latency still 10 cycles each; acc_out=0; add_cin=0 throughout.

Source files
------------

// File: rtl/mac8_pkg.sv
// Shared types and sizing for the 8x8 multiply-accumulate sequencer.
package mac8_pkg;

    localparam int WIDTH = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Unsigned wrap detection: a wrapped sum is smaller than either addend.
    function automatic logic add_wrapped(input logic [ACC_W-1:0] sum, input logic [ACC_W-1:0] addend);
        return (sum < addend);
    endfunction

endpackage

// File: rtl/mac8_seq_ctrl.sv
// Sequences a shared external 16-bit adder through shift-and-add multiply
// followed by a single accumulate step, with valid/ready on both sides.
module mac8_seq_ctrl
    import mac8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] add_a,
    output logic [ACC_W-1:0] add_b,
    output logic             add_cin,
    input  logic [ACC_W-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic             busy
);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [ACC_W-1:0] r_prod;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clr;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [ACC_W-1:0] w_add_a;
    logic [ACC_W-1:0] w_add_b;
    logic [ACC_W-1:0] w_a_shift;

    // Operand mux for the shared adder; idle and reset drive zeros.
    always_comb begin
        w_add_a   = {ACC_W{1'b0}};
        w_add_b   = {ACC_W{1'b0}};
        w_a_shift = {{(ACC_W-WIDTH){1'b0}}, r_a} << r_cnt;
        if (!rst_n) begin
            w_add_a = {ACC_W{1'b0}};
            w_add_b = {ACC_W{1'b0}};
        end else begin
            case (r_state)
                MUL: begin
                    w_add_a = r_prod;
                    w_add_b = r_b[r_cnt] ? w_a_shift : {ACC_W{1'b0}};
                end
                ACC: begin
                    w_add_a = r_clr ? {ACC_W{1'b0}} : r_acc;
                    w_add_b = r_prod;
                end
                default: begin
                    w_add_a = {ACC_W{1'b0}};
                    w_add_b = {ACC_W{1'b0}};
                end
            endcase
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_prod      <= {ACC_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_clr       <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
                        r_prod     <= {ACC_W{1'b0}};
                        r_cnt      <= {CNT_W{1'b0}};
                        r_clr      <= acc_clr;
                        r_ovf      <= acc_clr ? 1'b0 : r_ovf;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_prod <= add_sum;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ACC;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ACC: begin
                    r_acc       <= add_sum;
                    r_ovf       <= r_ovf | add_wrapped(add_sum, w_add_a);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // No same-cycle re-accept: in_ready rises only once back in IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign add_cin   = 1'b0;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign acc_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule
